ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Instruction-fetch front end on the consumer side of the PC/redirect interface of the toy_rv32i core.
- Takes redirect targets from branch/jal/jalr resolution, issues sequential word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs.
- Presents instructions to decode over a valid/ready interface.
- Flushes all buffered and in-flight fetches on redirect.

Parameters:
- DEPTH, 2, maximum fetches in flight plus buffered (outstanding + queued + to-be-discarded); power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target (PC+Imm or rs1+Imm from execute).
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch word address.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant.
- mem_rdata  in  32  instruction word.
- inst_valid  out  1  head entry holds an instruction.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  decode consumes the head this cycle.
- redirect_misaligned  out  1  registered pulse: the last redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - inst_valid=0, redirect_misaligned=0.
  - mem_req is 0 in any cycle where rst_n=0.
  - Reset mid-operation drops all state. Memory must not deliver rvalid for pre-reset grants after reset.
- Outputs and request rule:
  - mem_addr = fetch_pc (combinational).
  - mem_req = rst_n & !redirect_valid & (outstanding + queued + discard < DEPTH).
- Grant: when mem_req & mem_gnt at an edge:
  - Allocate the tail slot, tagged with pc = fetch_pc and filled = 0.
  - fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - outstanding++.
- Response: when mem_rvalid at an edge:
  - If discard>0: discard--, data dropped.
  - Otherwise the oldest unfilled slot gets data = mem_rdata, filled = 1; outstanding--.
  - mem_rvalid with outstanding==0 and discard==0 is a protocol violation; data is ignored.
- Head:
  - inst_valid = head slot filled; inst_data and inst_pc are taken from the head slot.
  - Latency: rvalid in cycle N gives inst_valid=1 in cycle N+1 if that slot is the head.
  - Pop on inst_valid & inst_ready; this frees the slot at that edge.
  - A pop and a grant in the same cycle are both performed.
  - A full queue stalls mem_req until a pop.
- Redirect (redirect_valid=1 at an edge), highest priority:
  - All queued slots are cleared, filled or not; inst_valid=0 next cycle.
  - discard += outstanding (including any grant this cycle, which is impossible since mem_req=0); outstanding=0.
  - An rvalid in the same cycle is dropped: if discard>0 it decrements discard first; otherwise it is counted against the flushed outstanding count.
  - A pop in the same cycle is a don't-care: the queue is flushed anyway.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - redirect_misaligned = |redirect_pc[1:0] for one cycle.
  - Fetch resumes the cycle after the redirect.
- Back-to-back redirects: the second overrides; discard accumulates correctly.
- Counter widths: clog2(DEPTH)+1 bits, so they never overflow given the request rule.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after each grant, inst_ready=1 -> mem_addr 0,4,8,...; inst_pc 0,4,8 with matching inst_data; first inst_valid 2 cycles after the first grant.
- DEPTH=2, inst_ready=0, gnt=1 -> exactly 2 grants (addr 0, 4), then mem_req=0. Raise inst_ready -> one pop per cycle and fetch resumes at 8.
- Two outstanding (addr 0, 4, no rvalid yet), redirect_pc=0x100 -> mem_req=0 in the redirect cycle. Next two rvalids are dropped, inst_valid stays 0. Next fetch addr 0x100; first delivered inst_pc = 0x100.
- Redirect in the same cycle as rvalid and inst_ready -> no instruction delivered, discard count correct. The subsequent stream starts at the target PC.
- redirect_pc=0x203 -> redirect_misaligned=1 for one cycle; next mem_addr=0x200.
- fetch_pc=0xFFFF_FFFC granted -> next mem_addr=0x0000_0000. Also: rst_n low mid-stream -> next cycle inst_valid=0, mem_req=0; after release mem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues sequential word fetches, buffers returned
// instructions with their PCs, and flushes everything on a redirect.
module ifetch_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        redirect_misaligned
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [CW-1:0] cnt_t;

   logic [31:0]      fetchPc_q, fetchPc_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [PW-1:0]    fill_q, fill_d;
   cnt_t             count_q, count_d;
   cnt_t             outst_q, outst_d;
   cnt_t             discard_q, discard_d;
   logic [DEPTH-1:0] filled_q, filled_d;
   logic             misaligned_q, misaligned_d;
   logic [31:0]      pcMem_q   [DEPTH];
   logic [31:0]      dataMem_q [DEPTH];

   logic        grant;
   logic        pop;
   logic        dropResp;
   logic        fillResp;
   logic        anyPending;
   logic [CW:0] occupancy;

   // count_q covers every allocated slot, so in-flight fetches are not counted twice
   assign occupancy  = {1'b0, count_q} + {1'b0, discard_q};
   assign mem_req    = rst_n & ~redirect_valid & (int'(occupancy) < DEPTH);
   assign mem_addr   = fetchPc_q;
   assign grant      = mem_req & mem_gnt;
   assign pop        = inst_valid & inst_ready;
   assign anyPending = (discard_q != '0) | (outst_q != '0);
   assign dropResp   = mem_rvalid & (discard_q != '0);
   assign fillResp   = mem_rvalid & (discard_q == '0) & (outst_q != '0);

   assign inst_valid          = filled_q[head_q];
   assign inst_data           = dataMem_q[head_q];
   assign inst_pc             = pcMem_q[head_q];
   assign redirect_misaligned = misaligned_q;

   always_comb begin
      fetchPc_d    = fetchPc_q;
      head_d       = head_q;
      tail_d       = tail_q;
      fill_d       = fill_q;
      count_d      = count_q + cnt_t'(grant) - cnt_t'(pop);
      outst_d      = outst_q + cnt_t'(grant) - cnt_t'(fillResp);
      discard_d    = dropResp ? discard_q - cnt_t'(1) : discard_q;
      filled_d     = filled_q;
      misaligned_d = 1'b0;
      if (grant) begin
         tail_d    = tail_q + PW'(1);
         fetchPc_d = fetchPc_q + 32'd4;
      end
      if (fillResp) begin
         filled_d[fill_q] = 1'b1;
         fill_d           = fill_q + PW'(1);
      end
      if (pop) begin
         filled_d[head_q] = 1'b0;
         head_d           = head_q + PW'(1);
      end
      // A same-cycle response is charged against whatever is still pending
      if (redirect_valid) begin
         fetchPc_d    = {redirect_pc[31:2], 2'b00};
         head_d       = '0;
         tail_d       = '0;
         fill_d       = '0;
         count_d      = '0;
         outst_d      = '0;
         filled_d     = '0;
         discard_d    = discard_q + outst_q - cnt_t'(mem_rvalid & anyPending);
         misaligned_d = |redirect_pc[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetchPc_q    <= RESET_PC;
         head_q       <= '0;
         tail_q       <= '0;
         fill_q       <= '0;
         count_q      <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         filled_q     <= '0;
         misaligned_q <= 1'b0;
      end else begin
         fetchPc_q    <= fetchPc_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         fill_q       <= fill_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         filled_q     <= filled_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Payload storage needs no reset; the filled bits qualify it
   always_ff @(posedge clk) begin
      if (grant) begin
         pcMem_q[tail_q] <= fetchPc_q;
      end
      if (fillResp) begin
         dataMem_q[fill_q] <= mem_rdata;
      end
   end
endmodule
